// File: rtl/sect_pt_check_pkg.sv
// Curve-parameter package shared by the point multiplier and the point checker.
// Holds the sect163r2 field/curve constants and the multiplier configuration.
// Latency helpers relate multiplier cycle count to end-to-end check latency.
package sect_pt_check_pkg;

  // sect163r2 field: GF(2^163) mod x^163 + x^7 + x^6 + x^3 + 1
  localparam int          SECT163R2_M  = 163;
  localparam logic [162:0] SECT163R2_FX = 163'hc9;

  // Curve y^2 + xy = x^3 + a*x^2 + b
  localparam bit          SECT163R2_A  = 1'b1;
  localparam logic [162:0] SECT163R2_B  = 163'h20a601907b8c953ca1481eb10512f78744a3205fd;

  // Point-multiplier constants: base point, its order and the cofactor
  localparam logic [162:0] SECT163R2_GX = 163'h3f0eba16286a2d57ea0991168d4994637e8343e36;
  localparam logic [162:0] SECT163R2_GY = 163'h0d51fbc6c71a0094fa2cdd545b11c5c0c797324f1;
  localparam logic [162:0] SECT163R2_N  = 163'h40000000000000000000292fe77e70c12a4234c33;
  localparam int          SECT163R2_H  = 2;

  // Digit-serial multiplier: number of digit steps per product
  localparam int MUL_NUM_CYCLE = 3;

  // f2m_mul start-to-done latency for a given digit-step count
  function automatic int mul_latency(input int num_cycle);
    return num_cycle + 1;
  endfunction

  // Point check start-to-done latency: four products plus the compare cycle
  function automatic int check_latency(input int lm);
    return 4 * (lm + 1) + 1;
  endfunction

endpackage

// File: rtl/sect_pt_check_if.sv
// Request/verdict bundle between a point-check client and sect_pt_check.
// Signals: clr, start, x, y (client -> checker); busy, done, on_curve (checker -> client).
// master = client side, slave = checker side.
interface sect_pt_check_if
  import sect_pt_check_pkg::*;
#(
  parameter int M = SECT163R2_M
);
  logic         clr;
  logic         start;
  logic [M-1:0] x;
  logic [M-1:0] y;
  logic         busy;
  logic         done;
  logic         on_curve;

  modport master (
    output clr, start, x, y,
    input  busy, done, on_curve
  );

  modport slave (
    input  clr, start, x, y,
    output busy, done, on_curve
  );
endinterface

// File: rtl/f2m_mul.sv
// Digit-serial GF(2^M) multiplier, c = a*b mod (x^M + FX), MSB digit first.
// Latency: done pulses NUM_CYCLE+1 cycles after start; c held until next start.
// No backpressure: start (re)loads operands at any time; clr aborts without done.
// Ports: clk, rst_n (async, active-low), clr (sync abort), start, a, b -> c, done.
module f2m_mul
  import sect_pt_check_pkg::*;
#(
  parameter int           M         = SECT163R2_M,
  parameter logic [M-1:0] FX        = SECT163R2_FX,
  parameter int           NUM_CYCLE = MUL_NUM_CYCLE
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         start,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic [M-1:0] c,
  output logic         done
);

  // Digit width; b is zero-padded on top to a whole number of digits
  localparam int D  = (M + NUM_CYCLE - 1) / NUM_CYCLE;
  localparam int W  = D * NUM_CYCLE;
  localparam int CW = $clog2(NUM_CYCLE + 1);

  logic [M-1:0]  a_q;
  logic [M-1:0]  acc_q;
  logic [M-1:0]  acc_nxt;
  logic [W-1:0]  b_q;
  logic [W-1:0]  b_ext;
  logic [CW-1:0] cnt_q;

  assign b_ext = W'(b);
  assign c     = acc_q;

  // One digit of Horner: acc = acc*x^D + a*digit, reducing after every shift
  // so the accumulator never leaves M bits.
  always_comb begin
    acc_nxt = acc_q;
    for (int j = W - 1; j >= W - D; j--) begin
      acc_nxt = {acc_nxt[M-2:0], 1'b0} ^ ({M{acc_nxt[M-1]}} & FX);
      if (b_q[j]) begin
        acc_nxt = acc_nxt ^ a_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      done  <= 1'b0;
    end else if (clr) begin
      cnt_q <= '0;
      done  <= 1'b0;
    end else if (start) begin
      a_q   <= a;
      b_q   <= b_ext;
      acc_q <= '0;
      cnt_q <= CW'(NUM_CYCLE);
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cnt_q != '0) begin
        acc_q <= acc_nxt;
        b_q   <= b_q << D;
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sect163r2_pt_check.sv
// sect163r2 point checker: sect_pt_check bound to the sect163r2 curve constants.
// Latency and backpressure identical to sect_pt_check.
// Ports: clk, rst (async, active-high), io (slave) as for sect_pt_check.
module sect163r2_pt_check
  import sect_pt_check_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  sect_pt_check_if.slave io
);

  sect_pt_check #(
    .M             (SECT163R2_M),
    .FX            (SECT163R2_FX),
    .A             (SECT163R2_A),
    .B             (SECT163R2_B),
    .NUM_CYCLE_MUL (MUL_NUM_CYCLE)
  ) u_core (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

endmodule

// File: rtl/sect_pt_check.sv
// Checks that affine (x, y) satisfies y^2 + xy = x^3 + A*x^2 + B over GF(2^M).
// Latency: done exactly 4*(Lm+1)+1 cycles after an accepted start (Lm = multiplier latency).
// No backpressure: start is only taken in IDLE and ignored while busy; clr aborts silently.
// Ports: clk, rst (async, active-high), io (slave): clr, start, x, y -> busy, done, on_curve.
module sect_pt_check
  import sect_pt_check_pkg::*;
#(
  parameter int           M             = SECT163R2_M,
  parameter logic [M-1:0] FX            = SECT163R2_FX,
  parameter bit           A             = SECT163R2_A,
  parameter logic [M-1:0] B             = SECT163R2_B,
  parameter int           NUM_CYCLE_MUL = MUL_NUM_CYCLE
) (
  input  logic           clk,
  input  logic           rst,
  sect_pt_check_if.slave io
);

  typedef enum logic [2:0] {
    IDLE,
    SQX,
    SQY,
    MXY,
    CUBE,
    CMP
  } state_t;

  state_t state_q, state_d;
  // High once the current multiply state has launched its product
  logic   issued_q, issued_d;

  logic [M-1:0] x_q, y_q, t1_q, t2_q, t3_q;
  logic         on_curve_q;

  logic         mul_rst_n;
  logic         mul_start;
  logic [M-1:0] mul_a, mul_b, mul_c;
  logic         mul_done;

  logic ld_ops, ld_t1, ld_t2, acc_t2, ld_t3, fin;
  logic verdict;

  assign mul_rst_n = ~rst;

  // Single shared multiplier for all four products
  f2m_mul #(
    .M         (M),
    .FX        (FX),
    .NUM_CYCLE (NUM_CYCLE_MUL)
  ) u_mul (
    .clk   (clk),
    .rst_n (mul_rst_n),
    .clr   (io.clr),
    .start (mul_start),
    .a     (mul_a),
    .b     (mul_b),
    .c     (mul_c),
    .done  (mul_done)
  );

  // t2 = y^2 + xy, t3 = x^3, t1 = x^2
  assign verdict = (t2_q == (t3_q ^ (A ? t1_q : '0) ^ B));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      issued_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      issued_q <= issued_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    issued_d  = issued_q;
    mul_start = 1'b0;
    mul_a     = x_q;
    mul_b     = x_q;
    ld_ops    = 1'b0;
    ld_t1     = 1'b0;
    ld_t2     = 1'b0;
    acc_t2    = 1'b0;
    ld_t3     = 1'b0;
    fin       = 1'b0;

    // Operands only matter in the launch cycle; the multiplier captures them.
    case (state_q)
      SQY:     begin mul_a = y_q;  mul_b = y_q; end
      MXY:     begin mul_a = x_q;  mul_b = y_q; end
      CUBE:    begin mul_a = t1_q; mul_b = x_q; end
      default: begin mul_a = x_q;  mul_b = x_q; end
    endcase

    case (state_q)
      IDLE: begin
        if (io.start) begin
          ld_ops   = 1'b1;
          issued_d = 1'b0;
          state_d  = SQX;
        end
      end
      SQX, SQY, MXY, CUBE: begin
        if (!issued_q) begin
          mul_start = 1'b1;
          issued_d  = 1'b1;
        end else if (mul_done) begin
          issued_d = 1'b0;
          case (state_q)
            SQX:     begin ld_t1  = 1'b1; state_d = SQY;  end
            SQY:     begin ld_t2  = 1'b1; state_d = MXY;  end
            MXY:     begin acc_t2 = 1'b1; state_d = CUBE; end
            default: begin ld_t3  = 1'b1; state_d = CMP;  end
          endcase
        end
      end
      CMP: begin
        fin     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // clr wins over everything, including a start or a finishing compare
    if (io.clr) begin
      state_d   = IDLE;
      issued_d  = 1'b0;
      mul_start = 1'b0;
      ld_ops    = 1'b0;
      ld_t1     = 1'b0;
      ld_t2     = 1'b0;
      acc_t2    = 1'b0;
      ld_t3     = 1'b0;
      fin       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q        <= '0;
      y_q        <= '0;
      t1_q       <= '0;
      t2_q       <= '0;
      t3_q       <= '0;
      on_curve_q <= 1'b0;
    end else begin
      if (ld_ops) begin
        x_q <= io.x;
        y_q <= io.y;
      end
      if (ld_t1) begin
        t1_q <= mul_c;
      end
      if (ld_t2) begin
        t2_q <= mul_c;
      end else if (acc_t2) begin
        t2_q <= t2_q ^ mul_c;
      end
      if (ld_t3) begin
        t3_q <= mul_c;
      end
      if (io.clr) begin
        on_curve_q <= 1'b0;
      end else if (fin) begin
        on_curve_q <= verdict;
      end
    end
  end

  // Verdict is shown combinationally in the done cycle, then held in on_curve_q
  assign io.busy     = (state_q != IDLE);
  assign io.done     = fin;
  assign io.on_curve = fin ? verdict : on_curve_q;

endmodule

// File: tb/tb_sect_pt_check.sv
module tb_sect_pt_check;

  localparam int M   = 163;
  localparam logic [M-1:0] FX = 163'hc9;
  localparam logic [M-1:0] B  = 163'h20a601907b8c953ca1481eb10512f78744a3205fd;
  localparam logic [M-1:0] GX = 163'h3f0eba16286a2d57ea0991168d4994637e8343e36;
  localparam logic [M-1:0] GY = 163'hd51fbc6c71a0094fa2cdd545b11c5c0c797324f1;
  localparam int NCM = 3;
  localparam int LM  = NCM + 1;          // multiplier start-to-done
  localparam int LAT = 4 * (LM + 1) + 1; // accepted start to done

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sect_pt_check_if #(.M(M)) io ();
  sect_pt_check_if #(.M(M)) io_w ();

  assign io_w.clr   = io.clr;
  assign io_w.start = io.start;
  assign io_w.x     = io.x;
  assign io_w.y     = io.y;

  sect_pt_check #(
    .M(M), .FX(FX), .A(1'b1), .B(B), .NUM_CYCLE_MUL(NCM)
  ) dut (
    .clk(clk), .rst(rst), .io(io)
  );

  sect163r2_pt_check wrp (
    .clk(clk), .rst(rst), .io(io_w)
  );

  // ---------------- reference model (plain field arithmetic) ----------------
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] r;
    logic [M-1:0] s;
    r = '0;
    s = a;
    for (int i = 0; i < M; i++) begin
      if (b[i]) r = r ^ s;
      s = s[M-1] ? ((s << 1) ^ FX) : (s << 1);
    end
    return r;
  endfunction

  function automatic bit on_curve_ref(input logic [M-1:0] x, input logic [M-1:0] y);
    logic [M-1:0] x2;
    x2 = gf_mul(x, x);
    return (gf_mul(y, y) ^ gf_mul(x, y)) == (gf_mul(x2, x) ^ x2 ^ B);
  endfunction

  function automatic logic [M-1:0] rnd();
    logic [M-1:0] v;
    v = '0;
    for (int i = 0; i < 6; i++) v = {v[M-33:0], 32'($urandom())};
    return v;
  endfunction

  // ---------------- scoreboard & bookkeeping ----------------
  typedef struct {
    int cyc;
    bit oc;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   busy_lo = 1;
  int   busy_hi = 0;
  bit   exp_oc  = 1'b0;
  int   n_chk   = 0;
  int   n_pass  = 0;
  logic [M-1:0] sqb;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint got, input longint want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, want, cyc);
  endtask

  // Monitor: pops an expectation whenever the DUT signals done
  always @(negedge clk) begin
    bit eb;
    exp_t e;
    eb = (cyc >= busy_lo) && (cyc <= busy_hi);
    chk("busy", io.busy, eb);
    chk("wrap_busy", io_w.busy, eb);
    if (io.done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", io.done, 0);
      end else begin
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("on_curve", io.on_curve, e.oc);
        chk("wrap_done", io_w.done, 1);
        chk("wrap_on_curve", io_w.on_curve, e.oc);
        exp_oc = e.oc;
      end
    end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
      chk("done_missing", cyc, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (!eb && !io.done) chk("on_curve_hold", io.on_curve, exp_oc);
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
    io.start = 1'b0;
    io.clr   = 1'b0;
    io.x     = rnd();
    io.y     = rnd();
  endtask

  // Drive start in the current cycle; the model decides whether it is taken
  task automatic issue(input logic [M-1:0] x, input logic [M-1:0] y, input bit with_clr);
    exp_t e;
    io.start = 1'b1;
    io.x     = x;
    io.y     = y;
    io.clr   = with_clr;
    if (!with_clr && cyc > busy_hi) begin
      busy_lo = cyc + 1;
      busy_hi = cyc + LAT;
      e.cyc   = cyc + LAT;
      e.oc    = on_curve_ref(x, y);
      sb.push_back(e);
    end
  endtask

  task automatic run_check(input logic [M-1:0] x, input logic [M-1:0] y);
    step();
    issue(x, y, 1'b0);
    while (cyc < busy_hi) step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1);
  end

  initial begin
    int c0;
    logic [M-1:0] rx, ry;
    io.start = 1'b0;
    io.clr   = 1'b0;
    io.x     = '0;
    io.y     = '0;
    sqb = B;
    repeat (M - 1) sqb = gf_mul(sqb, sqb);

    repeat (2) @(negedge clk);
    chk("rst_busy", io.busy, 0);
    chk("rst_done", io.done, 0);
    chk("rst_on_curve", io.on_curve, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Generator, single-bit corruptions, zero point, (0, sqrt(B))
    run_check(GX, GY);
    run_check(GX ^ 163'h1, GY);
    run_check(GX, GY ^ 163'h1);
    run_check('0, '0);
    run_check('0, sqb);

    // Second start two cycles into a check must be ignored
    step();
    issue(GX, GY, 1'b0);
    step();
    step();
    issue('0, '0, 1'b0);
    while (cyc < busy_hi) step();

    // clr during MXY
    step();
    issue(GX, GY, 1'b0);
    c0 = cyc;
    while (cyc < c0 + 2 * (LM + 1) + 2) step();
    io.clr  = 1'b1;
    busy_hi = cyc;
    void'(sb.pop_back());
    step();
    exp_oc = 1'b0;
    chk("clr_busy", io.busy, 0);
    chk("clr_on_curve", io.on_curve, 0);
    repeat (LAT + 2) step();

    // clr and start together in IDLE: clr wins
    step();
    issue(GX, GY, 1'b1);
    repeat (LAT + 2) step();

    // rst pulse during CUBE
    run_check(GX, GY);
    step();
    issue(GX, GY, 1'b0);
    c0 = cyc;
    while (cyc < c0 + 3 * (LM + 1) + 2) step();
    #1 rst = 1'b1;
    busy_hi = cyc - 1;
    void'(sb.pop_back());
    exp_oc = 1'b0;
    #1;
    chk("arst_busy", io.busy, 0);
    chk("arst_done", io.done, 0);
    chk("arst_on_curve", io.on_curve, 0);
    @(negedge clk);
    #2 rst = 1'b0;

    // Recovery and back-to-back checks (start in the cycle after done)
    run_check(GX, GY);
    run_check(GX, GX ^ GY);
    run_check(rnd(), rnd());
    run_check('0, sqb);

    // Randomized traffic with occasional ignored starts while busy
    for (int i = 0; i < 16; i++) begin
      rx = rnd();
      ry = rnd();
      if ($urandom_range(0, 2) == 0) begin
        rx = GX;
        ry = GX ^ GY;
      end
      repeat ($urandom_range(0, 2)) step();
      step();
      issue(rx, ry, 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, LAT - 1)) step();
        issue(rnd(), rnd(), 1'b0);
      end
      while (cyc < busy_hi) step();
    end

    repeat (5) step();
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
